// File: rtl/circular_shift_left_register_serial_unload_pkg.sv
// Shared types and defaults for the left-rotating register with serial unload.
package circular_shift_left_register_serial_unload_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH       = 5;
    localparam int DEFAULT_COUNT_WIDTH = 4;

endpackage

// File: rtl/circular_shift_left_register_serial_unload_cell.sv
// One register bit: parallel load has priority over the rotate input, else hold.
module circular_shift_cell (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic shift,
    input  logic par_bit,
    input  logic shift_bit,
    output logic q
);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            q <= 1'b0;
        else if (load)
            q <= par_bit;
        else if (shift)
            q <= shift_bit;
    end

endmodule

// File: rtl/circular_shift_left_register_serial_unload.sv
// Parallel-load register that rotates left on command, emitting each outgoing MSB serially.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  S_IDLE  | waiting; load captures parallel_in, start begins an unload
//  S_SHIFT | one rotation per edge, remaining counts down to 1
//  S_DONE  | last bit is on serial_out, done pulses, back to idle next
module circular_shift_left_register_serial_unload
    import circular_shift_left_register_serial_unload_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   load,
    input  logic [WIDTH-1:0]       parallel_in,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] rotate_count,
    output logic [WIDTH-1:0]       q,
    output logic                   serial_out,
    output logic                   serial_valid,
    output logic                   busy,
    output logic                   done
);

    state_t                 state;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   load_en;
    logic                   shift_en;

    assign load_en  = (state == S_IDLE) && load;
    assign shift_en = (state == S_SHIFT);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        // Rotating left: each bit takes its lower neighbour, bit 0 takes the MSB.
        localparam int SRC = (i == 0) ? WIDTH - 1 : i - 1;

        circular_shift_cell u_cell (
            .clock     (clock),
            .clear     (clear),
            .load      (load_en),
            .shift     (shift_en),
            .par_bit   (parallel_in[i]),
            .shift_bit (q[SRC]),
            .q         (q[i])
        );
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state        <= S_IDLE;
            remaining    <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!load && start) begin
                        remaining <= (rotate_count == '0) ? COUNT_WIDTH'(WIDTH) : rotate_count;
                        state     <= S_SHIFT;
                        busy      <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    serial_out   <= q[WIDTH-1];
                    serial_valid <= 1'b1;
                    remaining    <= remaining - COUNT_WIDTH'(1);
                    if (remaining == COUNT_WIDTH'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    serial_valid <= 1'b0;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    serial_valid <= 1'b0;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circular_shift_left_register_serial_unload.sv
// Directed bench for the left-rotating serial-unload register at WIDTH=5.
module tb_circular_shift_left_register_serial_unload;

    logic       clock = 1'b0;
    logic       clear;
    logic       load;
    logic [4:0] parallel_in;
    logic       start;
    logic [3:0] rotate_count;
    logic [4:0] q;
    logic       serial_out;
    logic       serial_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    circular_shift_left_register_serial_unload #(
        .WIDTH       (5),
        .COUNT_WIDTH (4)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .load         (load),
        .parallel_in  (parallel_in),
        .start        (start),
        .rotate_count (rotate_count),
        .q            (q),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [4:0] word);
        load        = 1'b1;
        parallel_in = word;
        tick();
        load        = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] count);
        start        = 1'b1;
        rotate_count = count;
        tick();
        start        = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] bits2;
        logic [6:0] bits3;
        int         busy_cycles;

        clear        = 1'b0;
        load         = 1'b0;
        start        = 1'b0;
        parallel_in  = '0;
        rotate_count = '0;
        #3;
        check("rst_q", q, 0);
        check("rst_sout", serial_out, 0);
        check("rst_valid", serial_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #4 clear = 1'b1;
        tick();

        // 1: single rotation
        do_load(5'b10110);
        check("t1_load_q", q, 5'b10110);
        do_start(4'd1);
        check("t1_busy_t0", busy, 1);
        check("t1_valid_t0", serial_valid, 0);
        tick();
        check("t1_valid", serial_valid, 1);
        check("t1_sout", serial_out, 1);
        check("t1_q", q, 5'b01101);
        check("t1_done", done, 1);
        tick();
        check("t1_valid_end", serial_valid, 0);
        check("t1_done_end", done, 0);
        check("t1_busy_end", busy, 0);
        check("t1_sout_hold", serial_out, 1);
        check("t1_q_hold", q, 5'b01101);

        // 2: count 0 means full width, non-destructive
        do_load(5'b10110);
        bits2 = 5'b10110;
        do_start(4'd0);
        busy_cycles = busy ? 1 : 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (busy) busy_cycles++;
            check("t2_valid", serial_valid, 1);
            check("t2_sout", serial_out, bits2[4-k]);
            check("t2_done", done, (k == 4) ? 1 : 0);
        end
        check("t2_q_at_done", q, 5'b10110);
        tick();
        check("t2_busy_cycles", busy_cycles, 6);
        check("t2_busy_end", busy, 0);
        check("t2_valid_end", serial_valid, 0);

        // 3: count beyond width wraps
        do_load(5'b00001);
        bits3 = 7'b0000100;
        do_start(4'd7);
        for (int k = 0; k < 7; k++) begin
            tick();
            check("t3_valid", serial_valid, 1);
            check("t3_sout", serial_out, bits3[6-k]);
            check("t3_done", done, (k == 6) ? 1 : 0);
        end
        check("t3_q_final", q, 5'b00100);
        tick();
        check("t3_busy_end", busy, 0);

        // 4: load and start together, load wins
        load         = 1'b1;
        start        = 1'b1;
        parallel_in  = 5'b11000;
        rotate_count = 4'd2;
        tick();
        load  = 1'b0;
        start = 1'b0;
        check("t4_q", q, 5'b11000);
        check("t4_busy", busy, 0);
        tick();
        check("t4_busy2", busy, 0);
        check("t4_valid", serial_valid, 0);
        check("t4_q2", q, 5'b11000);

        // 5: start and load ignored while running
        do_load(5'b10110);
        do_start(4'd3);
        tick();
        check("t5_sout1", serial_out, 1);
        check("t5_q1", q, 5'b01101);
        start        = 1'b1;
        load         = 1'b1;
        parallel_in  = 5'b11111;
        rotate_count = 4'd0;
        tick();
        check("t5_sout2", serial_out, 0);
        check("t5_q2", q, 5'b11010);
        check("t5_done2", done, 0);
        tick();
        check("t5_sout3", serial_out, 1);
        check("t5_q3", q, 5'b10101);
        check("t5_done3", done, 1);
        start = 1'b0;
        load  = 1'b0;
        tick();
        check("t5_busy_end", busy, 0);
        check("t5_q_end", q, 5'b10101);
        check("t5_valid_end", serial_valid, 0);

        // 6: async clear mid-shift
        do_load(5'b10110);
        do_start(4'd0);
        tick();
        tick();
        check("t6_q_pre", q, 5'b11010);
        check("t6_busy_pre", busy, 1);
        #2 clear = 1'b0;
        #1;
        check("t6_q", q, 0);
        check("t6_sout", serial_out, 0);
        check("t6_valid", serial_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        tick();
        tick();
        check("t6_done_held", done, 0);
        check("t6_busy_held", busy, 0);
        #2 clear = 1'b1;
        tick();
        do_load(5'b01011);
        check("t6_reload_q", q, 5'b01011);
        check("t6_reload_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
